// File: rtl/regfile_write_array_pkg.sv
// regfile_write_array_pkg: shared register-file dimensions
package regfile_write_array_pkg;
  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO_IDX = 0;
endpackage

// File: rtl/regfile_write_array_if.sv
// regfile_write_array_if: write request bus and flat register view
interface regfile_write_array_if
  import regfile_write_array_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int DEPTH = REG_DEPTH,
  parameter int ADDR_W = REG_ADDR_W
);
  logic ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [WIDTH-1:0] data_writeReg;
  logic [DEPTH*WIDTH-1:0] Q;
  modport master (output ctrl_writeEnable, ctrl_writeReg, data_writeReg, input Q);
  modport slave (input ctrl_writeEnable, ctrl_writeReg, data_writeReg, output Q);
endinterface

// File: rtl/regfile_write_array_register_w.sv
// regfile_write_array_register_w: WIDTH-bit enabled register with async clear
module regfile_write_array_register_w #(
  parameter int WIDTH = 32
) (
  input logic clock,
  input logic ctrl_reset_n,
  input logic en,
  input logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // clear immediately on reset, otherwise load only when enabled
  always_ff @(posedge clock or negedge ctrl_reset_n)
    if (!ctrl_reset_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/regfile_write_array.sv
// regfile_write_array: register storage and write decode, register 0 hardwired to zero
module regfile_write_array
  import regfile_write_array_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH,
  parameter int DEPTH = REG_DEPTH,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic clock,
  input logic ctrl_reset_n,
  regfile_write_array_if.slave bus
);
  logic [DEPTH-1:1] en;
  assign bus.Q[REG_ZERO_IDX*WIDTH +: WIDTH] = '0;
  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    assign en[i] = bus.ctrl_writeEnable && bus.ctrl_writeReg == ADDR_W'(i);
    regfile_write_array_register_w #(.WIDTH(WIDTH)) u_reg (
      .clock(clock),
      .ctrl_reset_n(ctrl_reset_n),
      .en(en[i]),
      .d(bus.data_writeReg),
      .q(bus.Q[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_regfile_write_array.sv
// tb_regfile_write_array: directed vector bench for the register write array
module tb_regfile_write_array;
  import regfile_write_array_pkg::*;
  localparam int QW = REG_DEPTH*REG_WIDTH;
  typedef struct {
    logic we;
    logic [REG_ADDR_W-1:0] a;
    logic [REG_WIDTH-1:0] d;
    int idx;
    logic [REG_WIDTH-1:0] exp;
  } vec_t;
  logic clock = 1'b0;
  logic ctrl_reset_n;
  int checks = 0;
  int fails = 0;
  vec_t v[$];
  logic [QW-1:0] expq;
  regfile_write_array_if bus();
  regfile_write_array dut (.clock(clock), .ctrl_reset_n(ctrl_reset_n), .bus(bus.slave));
  always #5 clock = ~clock;
  function automatic logic [REG_WIDTH-1:0] slice(int i);
    return bus.Q[i*REG_WIDTH +: REG_WIDTH];
  endfunction
  task automatic chk(string name, logic [QW-1:0] act, logic [QW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(logic we, logic [REG_ADDR_W-1:0] a, logic [REG_WIDTH-1:0] d);
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeReg = a;
    bus.data_writeReg = d;
  endtask
  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    ctrl_reset_n = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("reset_state", bus.Q, '0);
    drive(1'b1, 5'd5, 32'hDEAD_BEEF);
    repeat (3) edge_step();
    chk("reset_hold_write", bus.Q, '0);
    ctrl_reset_n = 1'b1;
    edge_step();
    chk("first_write_slice5", bus.Q[191:160], 32'hDEAD_BEEF);
    expq = '0;
    expq[191:160] = 32'hDEAD_BEEF;
    chk("first_write_full", bus.Q, expq);
    for (int i = 1; i < REG_DEPTH; i++)
      v.push_back('{1'b1, REG_ADDR_W'(i), 32'h1000_0000 + i, i, 32'h1000_0000 + i});
    v.push_back('{1'b1, 5'd0, 32'hFFFF_FFFF, 0, 32'h0});
    for (int k = 0; k < 4; k++)
      v.push_back('{1'b0, 5'd7, 32'h1234_5678, 7, 32'h1000_0007});
    v.push_back('{1'b1, 5'd3, 32'hAAAA_AAAA, 3, 32'hAAAA_AAAA});
    v.push_back('{1'b1, 5'd3, 32'h5555_5555, 3, 32'h5555_5555});
    foreach (v[n]) begin
      drive(v[n].we, v[n].a, v[n].d);
      edge_step();
      chk($sformatf("vec%0d_slice%0d", n, v[n].idx), slice(v[n].idx), v[n].exp);
    end
    drive(1'b0, 5'd7, 32'h1234_5678);
    edge_step();
    expq = '0;
    for (int i = 1; i < REG_DEPTH; i++) expq[i*REG_WIDTH +: REG_WIDTH] = 32'h1000_0000 + i;
    expq[3*REG_WIDTH +: REG_WIDTH] = 32'h5555_5555;
    chk("full_snapshot", bus.Q, expq);
    drive(1'b1, 5'd9, 32'h9999_0009);
    #1;
    chk("no_bypass_slice9", slice(9), 32'h1000_0009);
    edge_step();
    drive(1'b0, 5'd9, 32'h0);
    chk("read_port_sel9", slice(9), 32'h9999_0009);
    drive(1'b1, 5'd4, 32'hCAFE_F00D);
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    chk("async_reset_midcycle", bus.Q, '0);
    edge_step();
    chk("reset_edge_write", bus.Q, '0);
    ctrl_reset_n = 1'b1;
    drive(1'b0, 5'd4, 32'hCAFE_F00D);
    edge_step();
    chk("we0_after_reset", bus.Q, '0);
    drive(1'b1, 5'd31, 32'h0BAD_F00D);
    edge_step();
    expq = '0;
    expq[31*REG_WIDTH +: REG_WIDTH] = 32'h0BAD_F00D;
    chk("write_top_reg", bus.Q, expq);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
